logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined logic/shift unit for the execute stage. Successor to the
//  single-register RHS logic block: wider op set, configurable pipeline depth,
//  valid/ready handshake, result flags and a last-result register for op reuse.
//  Takes LHS/RHS operands from the operand-fetch stage and feeds the writeback mux.
// PARAMETERS
//  DATA_WIDTH  16  operand/result width, >= 4
//  STAGES      2   pipeline depth (latency), legal 1..4
//  OP_WIDTH    4   op field width, fixed at 4 (16 ops)
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           operands/op valid
//  in_ready   out  1           unit accepts this cycle
//  op         in   OP_WIDTH    operation select
//  lhs_in     in   DATA_WIDTH  left operand
//  rhs_in     in   DATA_WIDTH  right operand / shift amount
//  out_valid  out  1           result valid
//  out_ready  in   1           consumer accepts result
//  rhs_out    out  DATA_WIDTH  result
//  zero_out   out  1           rhs_out == 0
//  neg_out    out  1           rhs_out[DATA_WIDTH-1]
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids 0, all data/flag regs 0,
//    last_result 0. Outputs: out_valid 0, rhs_out 0, zero_out 0, neg_out 0, in_ready 1.
//  - Ops (SH = rhs_in[$clog2(DATA_WIDTH)-1:0], upper rhs bits ignored):
//    0 zero; 1 ~rhs; 2 lhs^rhs; 3 lhs&rhs; 4 rhs; 5 lhs|rhs; 6 all ones;
//    7 last_result; 8 ~(lhs&rhs); 9 ~(lhs|rhs); 10 ~(lhs^rhs); 11 lhs&~rhs;
//    12 lhs<<SH; 13 lhs>>SH logical; 14 lhs>>>SH arithmetic; 15 rotate-left lhs by SH.
//  - Handshake: advance = ~out_valid | out_ready; in_ready = advance. Transfer in
//    when in_valid & in_ready; transfer out when out_valid & out_ready.
//  - Pipeline: global enable = advance. Stage 1 computes op result and flags at
//    acceptance; stages 2..STAGES are pure delay (data, flags, valid). When enable,
//    stage1 valid <= in_valid (bubble if 0). Bubbles are not collapsed. While
//    stalled every stage holds; rhs_out/flags stable while out_valid & ~out_ready.
//  - Latency: result on outputs STAGES cycles after acceptance; throughput 1/cycle.
//  - last_result: updated with the stage-1 result on every accepted op (incl. op 7,
//    which rewrites the same value). Op 7 reads the value before that edge, so
//    back-to-back op X, op 7 yields X's result. Not updated on stall/bubbles.
//  - Flags computed from the stage-1 result, registered alongside it.
//  - Outputs when out_valid=0: data/flags hold last-loaded stage value (don't-care).
//  - in_valid with in_ready=0: inputs ignored, no state change; source must hold.
//  - rst_n low mid-operation: in-flight ops discarded immediately, no out_valid.
//  - Width: all ops modulo 2^DATA_WIDTH; shift by 0 returns lhs unchanged.
// STRUCTURE
//  - Package logic_pkg: op localparams (OP_ZERO..OP_ROTL), OP_WIDTH, shift-amount
//    width function.
//  - Sub-module logic_op_core: purely combinational op/lhs/rhs/last -> result;
//    logic_unit_pipe holds handshake, stage registers, last_result.
// TESTING (DATA_WIDTH=16, STAGES=2)
//  - Reset: rst_n low for 3 cycles with ops in flight -> out_valid 0, rhs_out 0,
//    in_ready 1; op 7 first after reset -> 0x0000, zero_out 1.
//  - Op 3, lhs 0xF0F0 rhs 0xFF00, out_ready 1 -> 2 cycles later out_valid 1,
//    rhs_out 0xF000, zero_out 0, neg_out 1.
//  - Stream ops 2 (0x00FF^0x0F0F), 7, 11 (0xFFFF,0x00FF) back-to-back -> 0x0FF0,
//    0x0FF0, 0xFF00 on consecutive cycles.
//  - Backpressure: 3 ops, out_ready 0 from first out_valid for 4 cycles -> in_ready
//    0, rhs_out held; release -> all 3 results in order, none lost or duplicated.
//  - Shifts: op 14 0x8000 rhs 0x0003 -> 0xF000; op 15 0x8001 rhs 0x0011 -> 0x0003;
//    op 13 0x8000 rhs 0x000F -> 0x0001; op 12 0x1234 rhs 0 -> 0x1234.
//  - Constants/bubbles: op 6 -> 0xFFFF neg 1; in_valid gap of 2 -> 2-cycle out_valid gap.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic/shift unit.
// Contents:
//   OP_WIDTH     width of the operation select field (fixed at 4, 16 ops)
//   OP_*         operation encodings, OP_ZERO (0) through OP_ROTL (15)
//   shamt_width  number of low rhs bits used as a shift/rotate amount
package logic_pkg;

    localparam int OP_WIDTH = 4;

    localparam logic [OP_WIDTH-1:0] OP_ZERO = 4'd0;
    localparam logic [OP_WIDTH-1:0] OP_NOTR = 4'd1;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 4'd2;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 4'd3;
    localparam logic [OP_WIDTH-1:0] OP_PASR = 4'd4;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 4'd5;
    localparam logic [OP_WIDTH-1:0] OP_ONES = 4'd6;
    localparam logic [OP_WIDTH-1:0] OP_LAST = 4'd7;
    localparam logic [OP_WIDTH-1:0] OP_NAND = 4'd8;
    localparam logic [OP_WIDTH-1:0] OP_NOR  = 4'd9;
    localparam logic [OP_WIDTH-1:0] OP_XNOR = 4'd10;
    localparam logic [OP_WIDTH-1:0] OP_ANDN = 4'd11;
    localparam logic [OP_WIDTH-1:0] OP_SHL  = 4'd12;
    localparam logic [OP_WIDTH-1:0] OP_SHR  = 4'd13;
    localparam logic [OP_WIDTH-1:0] OP_SRA  = 4'd14;
    localparam logic [OP_WIDTH-1:0] OP_ROTL = 4'd15;

    // Only the low log2(width) bits of rhs form the shift amount; the upper
    // bits are ignored so an oversized amount wraps instead of clearing lhs.
    function automatic int shamt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Purely combinational operation core of the logic unit.
// Ports:
//   op      operation select (logic_pkg::OP_*)
//   lhs     left operand
//   rhs     right operand, low bits double as shift amount
//   last    previously accepted result, returned by OP_LAST
//   result  operation result, modulo 2^DATA_WIDTH
module logic_op_core
    import logic_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic [DATA_WIDTH-1:0] last,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SH_WIDTH = shamt_width(DATA_WIDTH);
    localparam logic [SH_WIDTH:0] DW_AMT = (SH_WIDTH + 1)'(DATA_WIDTH);

    logic [SH_WIDTH-1:0] sh;
    logic [SH_WIDTH:0]   rot_back;
    logic [DATA_WIDTH-1:0] rotated;

    assign sh = rhs[SH_WIDTH-1:0];

    // A right shift by the full width yields zero, so a rotate by 0 cleanly
    // degenerates to lhs without a special case.
    assign rot_back = DW_AMT - {1'b0, sh};
    assign rotated  = (lhs << sh) | (lhs >> rot_back);

    always_comb begin
        result = '0;
        case (op)
            OP_ZERO: result = '0;
            OP_NOTR: result = ~rhs;
            OP_XOR:  result = lhs ^ rhs;
            OP_AND:  result = lhs & rhs;
            OP_PASR: result = rhs;
            OP_OR:   result = lhs | rhs;
            OP_ONES: result = '1;
            OP_LAST: result = last;
            OP_NAND: result = ~(lhs & rhs);
            OP_NOR:  result = ~(lhs | rhs);
            OP_XNOR: result = ~(lhs ^ rhs);
            OP_ANDN: result = lhs & ~rhs;
            OP_SHL:  result = lhs << sh;
            OP_SHR:  result = lhs >> sh;
            OP_SRA:  result = $signed(lhs) >>> sh;
            OP_ROTL: result = rotated;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic/shift unit for the execute stage.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid, in_ready    operand handshake from operand fetch
//   op, lhs_in, rhs_in    operation select and operands
//   out_valid, out_ready  result handshake to the writeback mux
//   rhs_out               result, STAGES cycles after acceptance
//   zero_out, neg_out     result == 0 / result MSB, aligned with rhs_out
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] lhs_in,
    input  logic [DATA_WIDTH-1:0] rhs_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] rhs_out,
    output logic                  zero_out,
    output logic                  neg_out
);

    logic [STAGES-1:0]     stage_valid;
    logic [STAGES-1:0]     stage_zero;
    logic [STAGES-1:0]     stage_neg;
    logic [DATA_WIDTH-1:0] stage_data [STAGES];
    logic [DATA_WIDTH-1:0] last_result;
    logic [DATA_WIDTH-1:0] core_result;
    logic                  advance;
    logic                  accept;

    logic_op_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .op     (op),
        .lhs    (lhs_in),
        .rhs    (rhs_in),
        .last   (last_result),
        .result (core_result)
    );

    // The whole pipe moves as one: any free slot at the output lets every
    // stage shift, bubbles included, so a stall freezes everything in place.
    assign advance  = ~stage_valid[STAGES-1] | out_ready;
    assign accept   = in_valid & advance;
    assign in_ready = advance;

    // Stage 1 captures the result and flags only for real ops; a bubble just
    // clears the valid bit and leaves stale data that nobody observes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            stage_zero  <= '0;
            stage_neg   <= '0;
            last_result <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else if (advance) begin
            stage_valid[0] <= in_valid;
            if (accept) begin
                stage_data[0] <= core_result;
                stage_zero[0] <= (core_result == '0);
                stage_neg[0]  <= core_result[DATA_WIDTH-1];
                last_result   <= core_result;
            end
            for (int i = 1; i < STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
                stage_zero[i]  <= stage_zero[i-1];
                stage_neg[i]   <= stage_neg[i-1];
            end
        end
    end

    assign out_valid = stage_valid[STAGES-1];
    assign rhs_out   = stage_data[STAGES-1];
    assign zero_out  = stage_zero[STAGES-1];
    assign neg_out   = stage_neg[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (DATA_WIDTH=16, STAGES=2).
// Single-op vectors come from a table; reset, streaming, backpressure and
// bubble behaviour are covered by hand-written sequences.
module tb_logic_unit_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] lhs_in;
    logic [15:0] rhs_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] rhs_out;
    logic        zero_out;
    logic        neg_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic [15:0] expected;
        string       name;
    } vec_t;

    vec_t vecs[20];

    logic_unit_pipe #(
        .DATA_WIDTH(16),
        .STAGES    (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .lhs_in   (lhs_in),
        .rhs_in   (rhs_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .rhs_out  (rhs_out),
        .zero_out (zero_out),
        .neg_out  (neg_out)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a sequence somehow never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle and settle just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] o, input logic [15:0] l,
                                  input logic [15:0] r);
        in_valid = 1'b1;
        op       = o;
        lhs_in   = l;
        rhs_in   = r;
    endtask

    // One isolated op: checks two-cycle latency, value and both flags
    task automatic run_single(input string name, input logic [3:0] o,
                              input logic [15:0] l, input logic [15:0] r,
                              input logic [15:0] expected);
        apply_stimulus(o, l, r);
        tick();
        in_valid = 1'b0;
        check_output({name, ".early_valid"}, 32'(out_valid), 32'd0);
        tick();
        check_output({name, ".valid"}, 32'(out_valid), 32'd1);
        check_output({name, ".data"}, 32'(rhs_out), 32'(expected));
        check_output({name, ".zero"}, 32'(zero_out), 32'(expected == 16'h0000));
        check_output({name, ".neg"}, 32'(neg_out), 32'(expected[15]));
        tick();
    endtask

    initial begin
        logic [15:0] got[$];
        logic [15:0] held;
        logic        in_pat[6];
        logic [15:0] ref_val;

        vecs[0]  = '{4'd3,  16'hF0F0, 16'hFF00, 16'hF000, "and"};
        vecs[1]  = '{4'd0,  16'h1234, 16'h5678, 16'h0000, "zero"};
        vecs[2]  = '{4'd1,  16'hAAAA, 16'h00FF, 16'hFF00, "notr"};
        vecs[3]  = '{4'd2,  16'h00FF, 16'h0F0F, 16'h0FF0, "xor"};
        vecs[4]  = '{4'd7,  16'h1111, 16'h2222, 16'h0FF0, "last_after_xor"};
        vecs[5]  = '{4'd4,  16'hABCD, 16'h1357, 16'h1357, "pass_rhs"};
        vecs[6]  = '{4'd5,  16'hF000, 16'h000F, 16'hF00F, "or"};
        vecs[7]  = '{4'd6,  16'h0000, 16'h0000, 16'hFFFF, "ones"};
        vecs[8]  = '{4'd8,  16'hFF00, 16'hF0F0, 16'h0FFF, "nand"};
        vecs[9]  = '{4'd9,  16'hFF00, 16'h00F0, 16'h000F, "nor"};
        vecs[10] = '{4'd10, 16'hAAAA, 16'h5555, 16'h0000, "xnor"};
        vecs[11] = '{4'd11, 16'hFFFF, 16'h00FF, 16'hFF00, "andn"};
        vecs[12] = '{4'd12, 16'h1234, 16'h0000, 16'h1234, "shl0"};
        vecs[13] = '{4'd12, 16'h0001, 16'h001F, 16'h8000, "shl_wrap_amt"};
        vecs[14] = '{4'd13, 16'h8000, 16'h000F, 16'h0001, "shr15"};
        vecs[15] = '{4'd14, 16'h8000, 16'h0003, 16'hF000, "sra_neg"};
        vecs[16] = '{4'd14, 16'h4000, 16'h0003, 16'h0800, "sra_pos"};
        vecs[17] = '{4'd15, 16'h8001, 16'h0011, 16'h0003, "rotl1"};
        vecs[18] = '{4'd15, 16'h1234, 16'h0004, 16'h2341, "rotl4"};
        vecs[19] = '{4'd7,  16'h0000, 16'hFFFF, 16'h2341, "last_after_rotl"};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'd0;
        lhs_in    = 16'h0;
        rhs_in    = 16'h0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) tick();
        check_output("rst.out_valid", 32'(out_valid), 32'd0);
        check_output("rst.rhs_out", 32'(rhs_out), 32'd0);
        check_output("rst.in_ready", 32'(in_ready), 32'd1);
        check_output("rst.zero", 32'(zero_out), 32'd0);
        check_output("rst.neg", 32'(neg_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset with two ops in flight: both must vanish, last_result cleared
        apply_stimulus(4'd6, 16'h0000, 16'h0000);
        tick();
        apply_stimulus(4'd5, 16'hF000, 16'h000F);
        tick();
        check_output("flight.valid_before", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("flight.async_valid", 32'(out_valid), 32'd0);
        check_output("flight.async_data", 32'(rhs_out), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("flight.rst_valid", 32'(out_valid), 32'd0);
            check_output("flight.rst_ready", 32'(in_ready), 32'd1);
            check_output("flight.rst_data", 32'(rhs_out), 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("flight.no_ghost", 32'(out_valid), 32'd0);
        end
        run_single("last_after_reset", 4'd7, 16'h5555, 16'hAAAA, 16'h0000);

        // Table of isolated ops
        for (int i = 0; i < 20; i++) begin
            run_single(vecs[i].name, vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].expected);
        end

        // Back-to-back stream, including op 7 right behind its source
        apply_stimulus(4'd2, 16'h00FF, 16'h0F0F);
        tick();
        apply_stimulus(4'd7, 16'h0000, 16'h0000);
        tick();
        check_output("stream.v0", 32'(out_valid), 32'd1);
        check_output("stream.d0", 32'(rhs_out), 32'h0FF0);
        apply_stimulus(4'd11, 16'hFFFF, 16'h00FF);
        tick();
        check_output("stream.v1", 32'(out_valid), 32'd1);
        check_output("stream.d1", 32'(rhs_out), 32'h0FF0);
        in_valid = 1'b0;
        tick();
        check_output("stream.v2", 32'(out_valid), 32'd1);
        check_output("stream.d2", 32'(rhs_out), 32'hFF00);
        tick();
        check_output("stream.drain", 32'(out_valid), 32'd0);

        // Backpressure: three ops, consumer stalls from the first result
        apply_stimulus(4'd4, 16'h0000, 16'h1111);
        tick();
        apply_stimulus(4'd4, 16'h0000, 16'h2222);
        tick();
        check_output("bp.first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        apply_stimulus(4'd4, 16'h0000, 16'h3333);
        #1;
        check_output("bp.ready_drop", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("bp.hold_ready", 32'(in_ready), 32'd0);
            check_output("bp.hold_valid", 32'(out_valid), 32'd1);
            check_output("bp.hold_data", 32'(rhs_out), 32'h1111);
        end
        out_ready = 1'b1;
        #1;
        check_output("bp.release_ready", 32'(in_ready), 32'd1);
        if (out_valid) got.push_back(rhs_out);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8 && got.size() < 3; i++) begin
            if (out_valid) got.push_back(rhs_out);
            tick();
        end
        check_output("bp.count", 32'(got.size()), 32'd3);
        for (int i = 0; i < got.size() && i < 3; i++) begin
            ref_val = 16'h1111 * 16'(i + 1);
            check_output("bp.order", 32'(got[i]), 32'(ref_val));
        end
        check_output("bp.drained", 32'(out_valid), 32'd0);

        // Bubbles: a two-cycle input gap must reappear as an output gap
        in_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        held   = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            if (in_pat[k]) begin
                if (k == 0) apply_stimulus(4'd6, 16'h0000, 16'h0000);
                else        apply_stimulus(4'd1, 16'h0000, 16'h00FF);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (k > 0) begin
                check_output("bubble.valid", 32'(out_valid), 32'(in_pat[k-1]));
                if (in_pat[k-1]) begin
                    held = (k == 1) ? 16'hFFFF : 16'hFF00;
                    check_output("bubble.data", 32'(rhs_out), 32'(held));
                    check_output("bubble.neg", 32'(neg_out), 32'd1);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
